fifo_axis_reader: RTL and testbench
===================================

FIFO_AXIS_READER -- requirements
Module: fifo_axis_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, the AXI-Stream data width in bits.
REQ-002 The block SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, the byte-enable width.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 32, the width of each statistics counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port fifo_data, input, DATA_WIDTH+KEEP_WIDTH+1 bits: the FIFO head word, packed {last, keep, data}, valid whenever fifo_empty=0 (show-ahead).
REQ-007 The block SHALL have port fifo_empty, input, 1 bit: the FIFO empty flag.
REQ-008 The block SHALL have port fifo_rd_en, output, 1 bit: pops the FIFO head word.
REQ-009 The block SHALL have ports m_axis_tdata (DATA_WIDTH), m_axis_tkeep (KEEP_WIDTH), m_axis_tlast (1) and m_axis_tvalid (1), all outputs: the AXI-Stream master.
REQ-010 The block SHALL have port m_axis_tready, input, 1 bit: the downstream ready.
REQ-011 The block SHALL have port flush, input, 1 bit: single-cycle request to discard the next whole packet.
REQ-012 The block SHALL have port dropping, output, 1 bit: high while the block is in state DROP.
REQ-013 The block SHALL have ports pkt_count, word_count and drop_count, outputs, each CNT_WIDTH bits: the statistics counters.

Function
REQ-014 The block SHALL hold a two-entry output buffer (head register plus skid register); m_axis_* SHALL be driven only from the head register, with no combinational input-to-output path.
REQ-015 fifo_rd_en SHALL equal !fifo_empty && (state==DROP || occupancy<2 || (occupancy==2 && head accepted this cycle)); it SHALL never be asserted while fifo_empty=1.
REQ-016 A word popped in state PASS SHALL go to the head register if the head is free or being accepted this cycle, and otherwise to the skid register; the skid register SHALL move to the head when the head is accepted.
REQ-017 Latency SHALL be one cycle: a word popped at edge N SHALL appear with m_axis_tvalid=1 after edge N.
REQ-018 Sustained throughput SHALL be one word per cycle while m_axis_tready=1 and fifo_empty=0.
REQ-019 While m_axis_tvalid=1 and m_axis_tready=0, tdata, tkeep and tlast SHALL hold stable, and tvalid SHALL stay high.
REQ-020 Word order SHALL be preserved; no word SHALL be duplicated, and no word SHALL be lost except by the drop rule.
REQ-021 The read side SHALL track in_pkt: set on popping a word with last=0, cleared on popping a word with last=1.
REQ-022 A flush pulse SHALL set flush_pending; a flush arriving while flush_pending=1 or state==DROP SHALL be ignored.
REQ-023 PASS->DROP SHALL occur when flush_pending=1 and in_pkt=0, clearing flush_pending; a flush seen with in_pkt=0 SHALL apply to the very next word popped.
REQ-024 In DROP, every popped word SHALL be discarded and SHALL increment drop_count; popping a word with last=1 SHALL return the state to PASS.
REQ-025 Words already in the output buffer SHALL still be delivered when DROP is entered.
REQ-026 word_count SHALL increment on every tvalid&&tready handshake; pkt_count SHALL increment on every handshake with tlast=1.
REQ-027 All counters SHALL wrap modulo 2^CNT_WIDTH without saturating.
REQ-028 A pop and an accept in the same cycle with occupancy 2 SHALL keep occupancy at 2.

Reset
REQ-029 Asserting rst_n low SHALL immediately set: m_axis_tvalid=0, fifo_rd_en=0, dropping=0, state PASS, occupancy 0, in_pkt=0, flush_pending=0, and all counters 0.
REQ-030 Asserting reset mid-packet SHALL discard buffered words; after release, output SHALL resume at the next FIFO word.
REQ-031 tdata, tkeep and tlast SHALL be don't-care while tvalid=0.

Verification
REQ-032 Back-to-back test: a 4-word packet (last on word 3) with tready=1 -> 4 consecutive beats, tlast on the 4th, pkt_count=1, word_count=4.
REQ-033 Backpressure test: tready=0 for 5 cycles mid-stream -> at most 2 words popped, output stable, and on tready=1 the order is preserved with no gaps.
REQ-034 Mid-packet flush test: flush during word 1 of packet A (3 words), then packet B (2 words) -> A fully delivered, B dropped (drop_count=2), dropping high exactly while B is popped.
REQ-035 Idle flush test: flush while idle, then packets C and D -> C dropped, D delivered, pkt_count=1.
REQ-036 Wrap test: CNT_WIDTH=4 with 17 single-word packets -> pkt_count=1.
REQ-037 Reset test: rst_n low while occupancy=2 -> tvalid=0 asynchronously and all counters 0.

Source files
------------

// File: rtl/fifo_axis_reader.sv
// Drains a show-ahead FIFO of {last, keep, data} words onto an AXI-Stream master
// through a two-entry head/skid buffer, with whole-packet flush and statistics.
module fifo_axis_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_WIDTH+KEEP_WIDTH:0]   fifo_data,
    input  logic                             fifo_empty,
    output logic                             fifo_rd_en,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tlast,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    input  logic                             flush,
    output logic                             dropping,
    output logic [CNT_WIDTH-1:0]             pkt_count,
    output logic [CNT_WIDTH-1:0]             word_count,
    output logic [CNT_WIDTH-1:0]             drop_count
);

    localparam int WORD_W = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_PASS = 1'b0,
        ST_DROP = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_flush_pending;
    logic                r_in_pkt;
    logic [WORD_W-1:0]   r_head;
    logic [WORD_W-1:0]   r_skid;
    logic                r_head_valid;
    logic                r_skid_valid;
    logic [CNT_WIDTH-1:0] r_pkt_count;
    logic [CNT_WIDTH-1:0] r_word_count;
    logic [CNT_WIDTH-1:0] r_drop_count;

    logic [1:0]          w_occ;
    logic                w_accept;
    logic                w_drop;
    logic                w_pop;
    logic                w_keep;
    logic                w_last_in;
    logic                w_head_free;

    // Pop/keep decisions; a pending flush outside a packet already discards the word popped now.
    always_comb begin
        w_occ       = {1'b0, r_head_valid} + {1'b0, r_skid_valid};
        w_accept    = r_head_valid & m_axis_tready;
        w_drop      = (r_state == ST_DROP) | (r_flush_pending & ~r_in_pkt);
        w_last_in   = fifo_data[WORD_W-1];
        w_head_free = ~r_head_valid | w_accept;
        if (!rst_n || fifo_empty) begin
            w_pop = 1'b0;
        end else if ((r_state == ST_DROP) || (w_occ < 2'd2) || w_accept) begin
            w_pop = 1'b1;
        end else begin
            w_pop = 1'b0;
        end
        w_keep = w_pop & ~w_drop;
    end

    // Head/skid output buffer; skid refills the head whenever the head is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head       <= '0;
            r_skid       <= '0;
            r_head_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_head_free) begin
            if (r_skid_valid) begin
                r_head       <= r_skid;
                r_head_valid <= 1'b1;
                r_skid       <= fifo_data;
                r_skid_valid <= w_keep;
            end else begin
                r_head       <= fifo_data;
                r_head_valid <= w_keep;
            end
        end else if (w_keep) begin
            r_skid       <= fifo_data;
            r_skid_valid <= 1'b1;
        end else begin
            r_skid_valid <= r_skid_valid;
        end
    end

    // Packet tracking, flush arming and PASS/DROP state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_PASS;
            r_flush_pending <= 1'b0;
            r_in_pkt        <= 1'b0;
        end else begin
            if (w_pop) begin
                r_in_pkt <= ~w_last_in;
            end else begin
                r_in_pkt <= r_in_pkt;
            end
            if ((r_state == ST_PASS) && w_drop) begin
                r_flush_pending <= 1'b0;
            end else if (flush && (r_state == ST_PASS) && !r_flush_pending) begin
                r_flush_pending <= 1'b1;
            end else begin
                r_flush_pending <= r_flush_pending;
            end
            case (r_state)
                ST_PASS: begin
                    if (w_drop && !(w_pop && w_last_in)) begin
                        r_state <= ST_DROP;
                    end else begin
                        r_state <= ST_PASS;
                    end
                end
                ST_DROP: begin
                    if (w_pop && w_last_in) begin
                        r_state <= ST_PASS;
                    end else begin
                        r_state <= ST_DROP;
                    end
                end
                default: r_state <= ST_PASS;
            endcase
        end
    end

    // Statistics counters, free-running modulo 2^CNT_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_count  <= '0;
            r_word_count <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_accept) begin
                r_word_count <= r_word_count + CNT_ONE;
            end else begin
                r_word_count <= r_word_count;
            end
            if (w_accept && r_head[WORD_W-1]) begin
                r_pkt_count <= r_pkt_count + CNT_ONE;
            end else begin
                r_pkt_count <= r_pkt_count;
            end
            if (w_pop && w_drop) begin
                r_drop_count <= r_drop_count + CNT_ONE;
            end else begin
                r_drop_count <= r_drop_count;
            end
        end
    end

    assign fifo_rd_en    = w_pop;
    assign m_axis_tdata  = r_head[DATA_WIDTH-1:0];
    assign m_axis_tkeep  = r_head[DATA_WIDTH+KEEP_WIDTH-1:DATA_WIDTH];
    assign m_axis_tlast  = r_head[WORD_W-1];
    assign m_axis_tvalid = r_head_valid;
    assign dropping      = (r_state == ST_DROP);
    assign pkt_count     = r_pkt_count;
    assign word_count    = r_word_count;
    assign drop_count    = r_drop_count;

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Directed and random stimulus for fifo_axis_reader, checked against a
// packet-level model (queues of FIFO words and of words owed downstream).
module tb_fifo_axis_reader;

    localparam int DW = 16;
    localparam int KW = 2;
    localparam int CW = 4;
    localparam int WW = DW + KW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [WW-1:0] fifo_data = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          flush = 1'b0;
    logic          dropping;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] word_count;
    logic [CW-1:0] drop_count;

    always #5 clk = ~clk;

    fifo_axis_reader #(
        .DATA_WIDTH(DW),
        .KEEP_WIDTH(KW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_data    (fifo_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .flush        (flush),
        .dropping     (dropping),
        .pkt_count    (pkt_count),
        .word_count   (word_count),
        .drop_count   (drop_count)
    );

    int            checks = 0;
    int            errors = 0;
    logic [WW-1:0] fifo_q[$];
    logic [WW-1:0] exp_q[$];
    int            m_word, m_pkt, m_drop;
    bit            m_pend, m_inpkt, m_dropping;
    bit            prev_hold;
    logic [WW-1:0] prev_out;
    int            cyc = 0;
    int            hs_n, first_hs, last_hs, pops_n, drop_hi_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic push_pkt(input int len);
        logic [WW-1:0] w;
        for (int i = 0; i < len; i++) begin
            w[DW-1:0]     = DW'($urandom());
            w[DW+KW-1:DW] = KW'($urandom());
            w[WW-1]       = (i == len - 1);
            fifo_q.push_back(w);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_word     = 0;
        m_pkt      = 0;
        m_drop     = 0;
        m_pend     = 1'b0;
        m_inpkt    = 1'b0;
        m_dropping = 1'b0;
        prev_hold  = 1'b0;
    endtask

    task automatic reset_counts();
        hs_n      = 0;
        first_hs  = -1;
        last_hs   = -1;
        pops_n    = 0;
        drop_hi_n = 0;
    endtask

    // Called at posedge+1; ends at the next posedge+1.
    task automatic step(input bit rdy, input bit fl, input bit avail);
        logic [WW-1:0] out_w, w;
        bit            pop, eff, exp_rd, last_pop, pend0, drop0;
        m_axis_tready = rdy;
        flush         = fl;
        fifo_empty    = !(avail && (fifo_q.size() > 0));
        fifo_data     = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        @(negedge clk);
        cyc++;
        out_w  = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        exp_rd = !fifo_empty && (m_dropping || exp_q.size() < 2 || (exp_q.size() == 2 && rdy));
        chk("tvalid", 32'(m_axis_tvalid), 32'(exp_q.size() != 0));
        chk("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        chk("dropping", 32'(dropping), 32'(m_dropping));
        chk("word_count", 32'(word_count), 32'(m_word % 16));
        chk("pkt_count", 32'(pkt_count), 32'(m_pkt % 16));
        chk("drop_count", 32'(drop_count), 32'(m_drop % 16));
        if (prev_hold) chk("hold", 32'(out_w), 32'(prev_out));
        if (dropping) drop_hi_n++;
        if (m_axis_tvalid && rdy && exp_q.size() > 0) begin
            chk("beat", 32'(out_w), 32'(exp_q[0]));
            m_word++;
            if (exp_q[0][WW-1]) m_pkt++;
            void'(exp_q.pop_front());
            hs_n++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
        end
        pop      = fifo_rd_en && !fifo_empty;
        eff      = m_dropping || (m_pend && !m_inpkt);
        pend0    = m_pend;
        drop0    = m_dropping;
        last_pop = 1'b0;
        if (pop) begin
            w = fifo_q.pop_front();
            pops_n++;
            last_pop = w[WW-1];
            m_inpkt  = !w[WW-1];
            if (eff) m_drop++;
            else exp_q.push_back(w);
        end
        m_dropping = eff && !last_pop;
        if (!drop0 && eff) m_pend = 1'b0;
        else if (fl && !pend0 && !drop0) m_pend = 1'b1;
        prev_hold = m_axis_tvalid && !rdy;
        prev_out  = out_w;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse from posedge+1, checked before any clock edge.
    task automatic do_reset();
        flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_dropping", 32'(dropping), 32'd0);
        chk("rst_counts", 32'({pkt_count, word_count, drop_count}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        reset_counts();
        #1 rst_n = 1'b0;
        #1;
        chk("init_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("init_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("init_counts", 32'({pkt_count, word_count, drop_count}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back 4-word packet.
        push_pkt(4);
        reset_counts();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1);
        chk("b2b_beats", 32'(hs_n), 32'd4);
        chk("b2b_span", 32'(last_hs - first_hs), 32'd3);
        chk("b2b_pkt", 32'(pkt_count), 32'd1);
        chk("b2b_words", 32'(word_count), 32'd4);

        // Backpressure mid-stream.
        push_pkt(6);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        reset_counts();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
        chk("bp_pops_le2", 32'(pops_n <= 2), 32'd1);
        reset_counts();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1);
        chk("bp_no_gap", 32'(last_hs - first_hs), 32'(hs_n - 1));
        chk("bp_pkt", 32'(pkt_count), 32'd2);

        // Flush during word 1 of A: A delivered, B dropped.
        push_pkt(3);
        push_pkt(2);
        reset_counts();
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1);
        chk("mid_drop", 32'(drop_count), 32'd2);
        chk("mid_pkt", 32'(pkt_count), 32'd3);
        chk("mid_drop_hi", 32'(drop_hi_n), 32'd1);

        // Idle flush: C dropped, D delivered.
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        chk("idle_dropping", 32'(dropping), 32'd1);
        push_pkt(2);
        push_pkt(3);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1);
        chk("idle_drop", 32'(drop_count), 32'd4);
        chk("idle_pkt", 32'(pkt_count), 32'd4);

        // Reset with two words buffered; output resumes at the next FIFO word.
        push_pkt(5);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        chk("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1);
        chk("post_rst_words", 32'(word_count), 32'd3);

        // Counter wrap with CNT_WIDTH=4.
        do_reset();
        for (int i = 0; i < 17; i++) push_pkt(1);
        for (int i = 0; i < 22; i++) step(1'b1, 1'b0, 1'b1);
        chk("wrap_pkt", 32'(pkt_count), 32'd1);
        chk("wrap_words", 32'(word_count), 32'd1);

        // Random traffic, flushes, gaps and backpressure.
        for (int i = 0; i < 400; i++) begin
            if (fifo_q.size() < 4 && $urandom_range(0, 3) == 0) push_pkt(int'($urandom_range(1, 5)));
            step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 8);
        end
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1);
        chk("drained", 32'(fifo_q.size() + exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
